// File: rtl/mux_verilog_pkg.sv
// Shared defaults and select-width helper for the N-to-1 lane multiplexer.
// Imported by the interface, the selector and the top level.
package mux_verilog_pkg;

    localparam int N_IN_DEF   = 4;
    localparam int DATA_W_DEF = 1;
    localparam int SEL_W_DEF  = 2;

    // Smallest select width able to address n lanes (at least one bit).
    function automatic int sel_w_min(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_verilog_if.sv
// Lane-mux bus: packed lanes, select and valid in; combinational, registered, valid and error out.
// The master drives inputs and observes results; the slave is the multiplexer.
interface mux_verilog_if
    import mux_verilog_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) ();

    logic [N_IN*DATA_W-1:0] Ent;
    logic [SEL_W-1:0]       Sel;
    logic                   In_Valid;
    logic [DATA_W-1:0]      Sal_Comb;
    logic [DATA_W-1:0]      Sal;
    logic                   Out_Valid;
    logic                   Sel_Err;

    modport master (
        output Ent, Sel, In_Valid,
        input  Sal_Comb, Sal, Out_Valid, Sel_Err
    );

    modport slave (
        input  Ent, Sel, In_Valid,
        output Sal_Comb, Sal, Out_Valid, Sel_Err
    );

endinterface

// File: rtl/mux_verilog_sel.sv
// Purely combinational lane selector; unused select codes yield zero, never X.
module mux_verilog_sel
    import mux_verilog_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic [N_IN*DATA_W-1:0] i_ent,
    input  logic [SEL_W-1:0]       i_sel,
    output logic [DATA_W-1:0]      o_dat
);

    always_comb begin
        o_dat = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (int'(i_sel) == k) begin
                o_dat = i_ent[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mux_verilog.sv
// N-to-1 lane multiplexer with zero-latency combinational output and a one-cycle registered output.
// Registered result, valid and select-error flag update on valid input; no backpressure.
module mux_verilog
    import mux_verilog_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    mux_verilog_if.slave     bus
);

    if (N_IN < 2) begin : g_bad_n_in
        $error("mux_verilog: N_IN must be at least 2");
    end
    if (((1 << SEL_W) < N_IN) || (SEL_W < sel_w_min(N_IN))) begin : g_bad_sel_w
        $error("mux_verilog: SEL_W too narrow for N_IN lanes");
    end

    logic [DATA_W-1:0] w_sel_dat;
    logic              w_sel_oor;
    logic [DATA_W-1:0] r_sal;
    logic              r_vld;
    logic              r_err;

    mux_verilog_sel #(
        .N_IN   (N_IN),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_sel (
        .i_ent (bus.Ent),
        .i_sel (bus.Sel),
        .o_dat (w_sel_dat)
    );

    assign w_sel_oor = (int'(bus.Sel) >= N_IN);

    // Reset wins over a valid input presented in the same cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sal <= '0;
            r_vld <= 1'b0;
            r_err <= 1'b0;
        end else if (bus.In_Valid) begin
            r_sal <= w_sel_dat;
            r_vld <= 1'b1;
            r_err <= w_sel_oor;
        end else begin
            r_vld <= 1'b0;
        end
    end

    assign bus.Sal_Comb  = w_sel_dat;
    assign bus.Sal       = r_sal;
    assign bus.Out_Valid = r_vld;
    assign bus.Sel_Err   = r_err;

endmodule

// File: tb/tb_mux_verilog.sv
// Bench for mux_verilog: default 4x1 instance plus a 3-lane instance for out-of-range selects.
module tb_mux_verilog;

    logic clk;
    logic rst;
    logic rst3;
    int   checks;
    int   errors;

    // Reference state for the 4-lane instance's registered outputs.
    logic m_sal;
    logic m_vld;
    logic m_err;

    mux_verilog_if #(.N_IN(4), .DATA_W(1), .SEL_W(2)) bus4 ();
    mux_verilog_if #(.N_IN(3), .DATA_W(1), .SEL_W(2)) bus3 ();

    mux_verilog #(.N_IN(4), .DATA_W(1), .SEL_W(2)) dut4 (
        .Clk (clk),
        .Rst (rst),
        .bus (bus4)
    );

    mux_verilog #(.N_IN(3), .DATA_W(1), .SEL_W(2)) dut3 (
        .Clk (clk),
        .Rst (rst3),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane n of the packed vector when the index names a lane, otherwise zero.
    function automatic logic ref_mux(input logic [3:0] ent, input int sel, input int n);
        if (sel >= n) return 1'b0;
        return logic'((ent >> sel) & 4'd1);
    endfunction

    task automatic apply4(input logic [3:0] ent, input logic [1:0] sel,
                          input logic vld, input logic r);
        bus4.Ent      = ent;
        bus4.Sel      = sel;
        bus4.In_Valid = vld;
        rst           = r;
    endtask

    // Advance one edge and move the reference model by the inputs present at that edge.
    task automatic tick4;
        logic [3:0] e;
        int         s;
        logic       v;
        logic       r;
        e = bus4.Ent;
        s = int'(bus4.Sel);
        v = bus4.In_Valid;
        r = rst;
        @(posedge clk);
        if (r) begin
            m_sal = 1'b0;
            m_vld = 1'b0;
            m_err = 1'b0;
        end else if (v) begin
            m_sal = ref_mux(e, s, 4);
            m_vld = 1'b1;
            m_err = (s >= 4);
        end else begin
            m_vld = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset;
        apply4(4'b1111, 2'(($urandom) % 4), 1'b1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick4();
            checks++;
            if ({bus4.Sal, bus4.Out_Valid, bus4.Sel_Err} !== 3'b000) begin
                errors++;
                $display("FAIL reset cycle %0d: Sal/Out_Valid/Sel_Err=%b%b%b want 000",
                         c, bus4.Sal, bus4.Out_Valid, bus4.Sel_Err);
            end
        end
        apply4(4'b0000, 2'b00, 1'b0, 1'b0);
        tick4();
    endtask

    task automatic test_sweep;
        logic [3:0] ent_t [18];
        logic [1:0] sel_t [18];
        logic       exp_t [18];
        ent_t = '{4'b0011, 4'b1011, 4'b1110, 4'b1100,
                  4'b1010, 4'b0110, 4'b1000, 4'b0011,
                  4'b1110, 4'b0100, 4'b1101, 4'b0101, 4'b0011,
                  4'b0101, 4'b0100, 4'b1001, 4'b1111, 4'b1011};
        sel_t = '{2'b00, 2'b00, 2'b01, 2'b01,
                  2'b10, 2'b10, 2'b11, 2'b11,
                  2'b00, 2'b00, 2'b01, 2'b01, 2'b10,
                  2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
        exp_t = '{1'b1, 1'b1, 1'b1, 1'b0,
                  1'b0, 1'b1, 1'b1, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 18; i++) begin
            apply4(ent_t[i], sel_t[i], 1'b1, 1'b0);
            #1;
            checks++;
            if (bus4.Sal_Comb !== exp_t[i]) begin
                errors++;
                $display("FAIL sweep_comb[%0d]: Sal_Comb=%b want %b", i, bus4.Sal_Comb, exp_t[i]);
            end
            tick4();
            checks++;
            if ({bus4.Sal, bus4.Out_Valid, bus4.Sel_Err} !== {exp_t[i], 2'b10}) begin
                errors++;
                $display("FAIL sweep_reg[%0d]: Sal/Out_Valid/Sel_Err=%b%b%b want %b10",
                         i, bus4.Sal, bus4.Out_Valid, bus4.Sel_Err, exp_t[i]);
            end
        end
    endtask

    task automatic test_hold;
        apply4(4'b0110, 2'b10, 1'b1, 1'b0);
        tick4();
        checks++;
        if ({bus4.Sal, bus4.Out_Valid} !== 2'b11) begin
            errors++;
            $display("FAIL hold_capture: Sal/Out_Valid=%b%b want 11", bus4.Sal, bus4.Out_Valid);
        end
        apply4(4'b0000, 2'b10, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus4.Sal_Comb !== 1'b0) begin
            errors++;
            $display("FAIL hold_comb: Sal_Comb=%b want 0", bus4.Sal_Comb);
        end
        for (int c = 0; c < 2; c++) begin
            tick4();
            checks++;
            if ({bus4.Sal, bus4.Out_Valid} !== 2'b10) begin
                errors++;
                $display("FAIL hold_cycle%0d: Sal/Out_Valid=%b%b want 10", c, bus4.Sal, bus4.Out_Valid);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] e;
        logic [1:0] s;
        for (int i = 0; i < 300; i++) begin
            e = 4'($urandom);
            s = 2'($urandom);
            apply4(e, s, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0));
            #1;
            checks++;
            if (bus4.Sal_Comb !== ref_mux(e, int'(s), 4)) begin
                errors++;
                $display("FAIL rand_comb[%0d]: Ent=%b Sel=%0d Sal_Comb=%b want %b",
                         i, e, s, bus4.Sal_Comb, ref_mux(e, int'(s), 4));
            end
            tick4();
            checks++;
            if ({bus4.Sal, bus4.Out_Valid, bus4.Sel_Err} !== {m_sal, m_vld, m_err}) begin
                errors++;
                $display("FAIL rand_reg[%0d]: Sal/Out_Valid/Sel_Err=%b%b%b want %b%b%b",
                         i, bus4.Sal, bus4.Out_Valid, bus4.Sel_Err, m_sal, m_vld, m_err);
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [2:0] ent3_t [5];
        logic [1:0] sel3_t [5];
        logic       vld3_t [5];
        logic       cmb3_t [5];
        logic [2:0] reg3_t [5];
        // Expected {Sal, Out_Valid, Sel_Err} after each edge.
        ent3_t = '{3'b111, 3'b100, 3'b010, 3'b111, 3'b000};
        sel3_t = '{2'b11,  2'b10,  2'b01,  2'b11,  2'b01};
        vld3_t = '{1'b1,   1'b1,   1'b0,   1'b1,   1'b0};
        cmb3_t = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b0};
        reg3_t = '{3'b011, 3'b110, 3'b100, 3'b011, 3'b001};
        rst3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus3.Ent      = ent3_t[i];
            bus3.Sel      = sel3_t[i];
            bus3.In_Valid = vld3_t[i];
            #1;
            checks++;
            if (bus3.Sal_Comb !== cmb3_t[i]) begin
                errors++;
                $display("FAIL oor_comb[%0d]: Sal_Comb=%b want %b", i, bus3.Sal_Comb, cmb3_t[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({bus3.Sal, bus3.Out_Valid, bus3.Sel_Err} !== reg3_t[i]) begin
                errors++;
                $display("FAIL oor_reg[%0d]: Sal/Out_Valid/Sel_Err=%b%b%b want %b",
                         i, bus3.Sal, bus3.Out_Valid, bus3.Sel_Err, reg3_t[i]);
            end
        end
        rst3 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus3.Sal, bus3.Out_Valid, bus3.Sel_Err} !== 3'b000) begin
            errors++;
            $display("FAIL oor_reset: Sal/Out_Valid/Sel_Err=%b%b%b want 000",
                     bus3.Sal, bus3.Out_Valid, bus3.Sel_Err);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        m_sal         = 1'b0;
        m_vld         = 1'b0;
        m_err         = 1'b0;
        rst           = 1'b1;
        rst3          = 1'b1;
        bus4.Ent      = 4'b1111;
        bus4.Sel      = 2'b00;
        bus4.In_Valid = 1'b1;
        bus3.Ent      = 3'b000;
        bus3.Sel      = 2'b00;
        bus3.In_Valid = 1'b0;
        #1;
        test_reset();
        test_sweep();
        test_hold();
        test_random();
        test_out_of_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
